// File: rtl/ae_pkg.sv
// Shared types and constants for the AE sensor write path: scheduler and
// write-engine state encodings, group-hold values, default sensor register
// addresses and the gain saturation helper.
package ae_pkg;

  // Scheduler states
  typedef enum logic [2:0] {
    INIT_FETCH = 3'd0,
    INIT_WR    = 3'd1,
    RUN_IDLE   = 3'd2,
    ARMED      = 3'd3,
    BURST_WR   = 3'd4
  } ae_state_e;

  // Single-write engine states
  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_REQ  = 2'd1,
    ENG_GAP  = 2'd2
  } eng_state_e;

  // Group-hold register values
  localparam logic [7:0] HOLD_OPEN  = 8'h00;
  localparam logic [7:0] HOLD_CLOSE = 8'h10;

  // Default sensor register addresses, also used by the AE top-level glue
  localparam logic [15:0] EXP_REG_H_DEF = 16'h3501;
  localparam logic [15:0] EXP_REG_L_DEF = 16'h3502;
  localparam logic [15:0] GAIN_REG_DEF  = 16'h350B;
  localparam logic [15:0] HOLD_REG_DEF  = 16'h3208;

  // Index of the last write in an AE burst (hold open .. hold close)
  localparam logic [2:0] BURST_LAST = 3'd4;

  // Clamp a 16-bit AE gain into the 8-bit sensor gain register
  function automatic logic [7:0] sat_gain(input logic [15:0] g);
    logic [7:0] r;
    if (g > 16'd255) begin
      r = 8'hFF;
    end else begin
      r = g[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ae_i2c_retry.sv
// Single-write request engine: accepts one address/value on start, holds
// i2c_req until i2c_done, and re-requests after a NACK up to MAX_RETRY extra
// times. fin pulses once per write; dropped qualifies fin when all attempts
// were NACKed.
module ae_i2c_retry
  import ae_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        i2c_done,
  input  logic        i2c_err,
  output logic        i2c_req,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data,
  output logic        fin,
  output logic        dropped
);

  localparam logic [1:0] MAX_RETRY_C = 2'(MAX_RETRY);

  eng_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  retry_q, retry_d;
  logic        fin_q, fin_d;
  logic        drop_q, drop_d;

  // Next-state logic for one write with NACK retries; a done pulse outside
  // ENG_REQ is ignored because req is low there
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    retry_d = retry_q;
    fin_d   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ENG_IDLE: begin
        if (start) begin
          addr_d  = wr_addr;
          data_d  = wr_data;
          retry_d = 2'd0;
          req_d   = 1'b1;
          state_d = ENG_REQ;
        end else begin
          req_d   = 1'b0;
        end
      end
      ENG_REQ: begin
        if (i2c_done) begin
          req_d = 1'b0;
          if (!i2c_err) begin
            fin_d   = 1'b1;
            state_d = ENG_IDLE;
          end else if (retry_q == MAX_RETRY_C) begin
            fin_d   = 1'b1;
            drop_d  = 1'b1;
            state_d = ENG_IDLE;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ENG_GAP;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ENG_GAP: begin
        // One idle cycle between a NACKed attempt and its retry
        req_d   = 1'b1;
        state_d = ENG_REQ;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ENG_IDLE;
      end
    endcase
  end

  // Engine registers; reset drops the request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENG_IDLE;
      req_q   <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      retry_q <= 2'd0;
      fin_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      fin_q   <= fin_d;
      drop_q  <= drop_d;
    end
  end

  assign i2c_req  = req_q;
  assign i2c_addr = addr_q;
  assign i2c_data = data_q;
  assign fin      = fin_q;
  assign dropped  = drop_q;

endmodule

// File: rtl/ae_sensor_write_sched.sv
// Sensor write scheduler: walks the power-up config LUT, then commits AE
// exposure/gain results as group-hold bursts started on a vsync rising edge.
// Sole owner of the I2C master request port.
module ae_sensor_write_sched
  import ae_pkg::*;
#(
  parameter int          LUT_AW    = 8,
  parameter logic [15:0] EXP_REG_H = EXP_REG_H_DEF,
  parameter logic [15:0] EXP_REG_L = EXP_REG_L_DEF,
  parameter logic [15:0] GAIN_REG  = GAIN_REG_DEF,
  parameter logic [15:0] HOLD_REG  = HOLD_REG_DEF,
  parameter int          MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LUT_AW-1:0] lut_index,
  input  logic [23:0]       lut_data,
  input  logic [LUT_AW-1:0] lut_size,
  input  logic              ae_valid,
  input  logic [15:0]       ae_time,
  input  logic [15:0]       ae_gain,
  input  logic              vsync,
  output logic              i2c_req,
  output logic [15:0]       i2c_addr,
  output logic [7:0]        i2c_data,
  input  logic              i2c_done,
  input  logic              i2c_err,
  output logic              init_done,
  output logic              busy,
  output logic              err,
  output logic [15:0]       exp_applied,
  output logic [7:0]        gain_applied,
  output logic [7:0]        update_cnt
);

  ae_state_e         state_q, state_d;
  logic [LUT_AW-1:0] lut_index_q, lut_index_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [15:0]       exp_applied_q, exp_applied_d;
  logic [7:0]        gain_applied_q, gain_applied_d;
  logic [7:0]        update_cnt_q, update_cnt_d;
  logic              vsync_q;
  logic              p_valid_q, p_valid_d;
  logic [15:0]       p_time_q, p_time_d;
  logic [7:0]        p_gain_q, p_gain_d;
  logic [15:0]       w_time_q, w_time_d;
  logic [7:0]        w_gain_q, w_gain_d;
  logic [2:0]        step_q, step_d;

  logic              vsync_rise_s;
  logic              clear_pend_s;
  logic              start_s;
  logic [15:0]       start_addr_s;
  logic [7:0]        start_data_s;
  logic [2:0]        sel_step_s;
  logic [15:0]       burst_addr_s;
  logic [7:0]        burst_data_s;
  logic              eng_fin_s;
  logic              eng_drop_s;

  assign vsync_rise_s = vsync & ~vsync_q;

  // Select which burst word gets issued next: word 0 from ARMED, else step+1
  always_comb begin
    if (state_q == BURST_WR) begin
      sel_step_s = step_q + 3'd1;
    end else begin
      sel_step_s = 3'd0;
    end
  end

  // Address/value of each burst word; the group hold brackets the update so
  // the sensor latches exposure and gain on the same frame
  always_comb begin
    case (sel_step_s)
      3'd0: begin
        burst_addr_s = HOLD_REG;
        burst_data_s = HOLD_OPEN;
      end
      3'd1: begin
        burst_addr_s = EXP_REG_H;
        burst_data_s = w_time_q[15:8];
      end
      3'd2: begin
        burst_addr_s = EXP_REG_L;
        burst_data_s = w_time_q[7:0];
      end
      3'd3: begin
        burst_addr_s = GAIN_REG;
        burst_data_s = w_gain_q;
      end
      default: begin
        burst_addr_s = HOLD_REG;
        burst_data_s = HOLD_CLOSE;
      end
    endcase
  end

  // Scheduler next-state: LUT walk, pending-update arbitration and bursts
  always_comb begin
    state_d        = state_q;
    lut_index_d    = lut_index_q;
    init_done_d    = init_done_q;
    err_d          = err_q;
    exp_applied_d  = exp_applied_q;
    gain_applied_d = gain_applied_q;
    update_cnt_d   = update_cnt_q;
    w_time_d       = w_time_q;
    w_gain_d       = w_gain_q;
    step_d         = step_q;
    clear_pend_s   = 1'b0;
    start_s        = 1'b0;
    start_addr_s   = burst_addr_s;
    start_data_s   = burst_data_s;
    case (state_q)
      INIT_FETCH: begin
        if (lut_index_q == lut_size) begin
          init_done_d = 1'b1;
          state_d     = RUN_IDLE;
        end else begin
          start_s      = 1'b1;
          start_addr_s = lut_data[23:8];
          start_data_s = lut_data[7:0];
          state_d      = INIT_WR;
        end
      end
      INIT_WR: begin
        if (eng_fin_s) begin
          // A dropped entry is skipped just like a successful one
          lut_index_d = lut_index_q + LUT_AW'(1);
          err_d       = err_q | eng_drop_s;
          state_d     = INIT_FETCH;
        end else begin
          state_d     = INIT_WR;
        end
      end
      RUN_IDLE: begin
        if (p_valid_q) begin
          if ({p_time_q, p_gain_q} == {exp_applied_q, gain_applied_q}) begin
            clear_pend_s = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end else begin
          state_d = RUN_IDLE;
        end
      end
      ARMED: begin
        if (vsync_rise_s) begin
          w_time_d     = p_time_q;
          w_gain_d     = p_gain_q;
          clear_pend_s = 1'b1;
          step_d       = 3'd0;
          start_s      = 1'b1;
          state_d      = BURST_WR;
        end else begin
          state_d = ARMED;
        end
      end
      BURST_WR: begin
        if (eng_fin_s) begin
          err_d = err_q | eng_drop_s;
          if (step_q == BURST_LAST) begin
            exp_applied_d  = w_time_q;
            gain_applied_d = w_gain_q;
            update_cnt_d   = update_cnt_q + 8'd1;
            state_d        = RUN_IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            start_s = 1'b1;
          end
        end else begin
          state_d = BURST_WR;
        end
      end
      default: begin
        state_d = INIT_FETCH;
      end
    endcase

    // Pending slot: a new pulse always wins over a same-cycle clear
    if (ae_valid) begin
      p_valid_d = 1'b1;
      p_time_d  = ae_time;
      p_gain_d  = sat_gain(ae_gain);
    end else if (clear_pend_s) begin
      p_valid_d = 1'b0;
      p_time_d  = p_time_q;
      p_gain_d  = p_gain_q;
    end else begin
      p_valid_d = p_valid_q;
      p_time_d  = p_time_q;
      p_gain_d  = p_gain_q;
    end

    busy_d = (state_d == INIT_FETCH) || (state_d == INIT_WR) ||
             (state_d == BURST_WR);
  end

  // Scheduler state, status outputs and pending/working registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= INIT_FETCH;
      lut_index_q    <= '0;
      init_done_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      exp_applied_q  <= 16'h0000;
      gain_applied_q <= 8'h00;
      update_cnt_q   <= 8'h00;
      vsync_q        <= 1'b0;
      p_valid_q      <= 1'b0;
      p_time_q       <= 16'h0000;
      p_gain_q       <= 8'h00;
      w_time_q       <= 16'h0000;
      w_gain_q       <= 8'h00;
      step_q         <= 3'd0;
    end else begin
      state_q        <= state_d;
      lut_index_q    <= lut_index_d;
      init_done_q    <= init_done_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      exp_applied_q  <= exp_applied_d;
      gain_applied_q <= gain_applied_d;
      update_cnt_q   <= update_cnt_d;
      vsync_q        <= vsync;
      p_valid_q      <= p_valid_d;
      p_time_q       <= p_time_d;
      p_gain_q       <= p_gain_d;
      w_time_q       <= w_time_d;
      w_gain_q       <= w_gain_d;
      step_q         <= step_d;
    end
  end

  ae_i2c_retry #(
    .MAX_RETRY (MAX_RETRY)
  ) u_retry (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s),
    .wr_addr  (start_addr_s),
    .wr_data  (start_data_s),
    .i2c_done (i2c_done),
    .i2c_err  (i2c_err),
    .i2c_req  (i2c_req),
    .i2c_addr (i2c_addr),
    .i2c_data (i2c_data),
    .fin      (eng_fin_s),
    .dropped  (eng_drop_s)
  );

  assign lut_index    = lut_index_q;
  assign init_done    = init_done_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign exp_applied  = exp_applied_q;
  assign gain_applied = gain_applied_q;
  assign update_cnt   = update_cnt_q;

endmodule

// File: tb/tb_ae_sensor_write_sched.sv
// Directed bench for ae_sensor_write_sched with a small I2C slave model that
// logs every completed attempt and can NACK or stall a chosen address.
module tb_ae_sensor_write_sched;

  logic        clk;
  logic        rst;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic [7:0]  lut_size;
  logic        ae_valid;
  logic [15:0] ae_time;
  logic [15:0] ae_gain;
  logic        vsync;
  logic        i2c_req;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data;
  logic        i2c_done;
  logic        i2c_err;
  logic        init_done;
  logic        busy;
  logic        err;
  logic [15:0] exp_applied;
  logic [7:0]  gain_applied;
  logic [7:0]  update_cnt;

  logic [23:0] lut_mem [0:255];
  logic [15:0] log_addr [0:63];
  logic [7:0]  log_data [0:63];
  int          log_n;
  logic [15:0] err_addr;
  logic [15:0] hold_addr;
  int          n_checks;
  int          n_errors;

  assign lut_data = lut_mem[lut_index];

  ae_sensor_write_sched dut (
    .clk          (clk),
    .rst          (rst),
    .lut_index    (lut_index),
    .lut_data     (lut_data),
    .lut_size     (lut_size),
    .ae_valid     (ae_valid),
    .ae_time      (ae_time),
    .ae_gain      (ae_gain),
    .vsync        (vsync),
    .i2c_req      (i2c_req),
    .i2c_addr     (i2c_addr),
    .i2c_data     (i2c_data),
    .i2c_done     (i2c_done),
    .i2c_err      (i2c_err),
    .init_done    (init_done),
    .busy         (busy),
    .err          (err),
    .exp_applied  (exp_applied),
    .gain_applied (gain_applied),
    .update_cnt   (update_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // I2C slave: completes a request two cycles after it is seen
  initial begin : slave
    int wait_cnt;
    wait_cnt = 0;
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_err  = 1'b0;
      if (i2c_req && (i2c_addr != hold_addr)) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          i2c_done = 1'b1;
          i2c_err  = (i2c_addr == err_addr);
          if (log_n < 64) begin
            log_addr[log_n] = i2c_addr;
            log_data[log_n] = i2c_data;
          end
          log_n++;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic pulse_ae(input logic [15:0] t, input logic [15:0] g);
    ae_valid = 1'b1;
    ae_time  = t;
    ae_gain  = g;
    @(negedge clk);
    ae_valid = 1'b0;
  endtask

  task automatic wait_update(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (update_cnt !== target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(update_cnt === target), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(init_done), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] t, input logic [7:0] g);
    check_eq({tag, "_n"}, 32'(log_n), 32'd5);
    check_eq({tag, "_a0"}, {log_addr[0], 8'h00, log_data[0]}, 32'h3208_0000);
    check_eq({tag, "_a1"}, {log_addr[1], 8'h00, log_data[1]}, {16'h3501, 8'h00, t[15:8]});
    check_eq({tag, "_a2"}, {log_addr[2], 8'h00, log_data[2]}, {16'h3502, 8'h00, t[7:0]});
    check_eq({tag, "_a3"}, {log_addr[3], 8'h00, log_data[3]}, {16'h350B, 8'h00, g});
    check_eq({tag, "_a4"}, {log_addr[4], 8'h00, log_data[4]}, 32'h3208_0010);
  endtask

  initial begin : main
    int cnt3501;
    n_checks  = 0;
    n_errors  = 0;
    log_n     = 0;
    err_addr  = 16'hFFFF;
    hold_addr = 16'hFFFF;
    for (int i = 0; i < 256; i++) lut_mem[i] = 24'h000000;
    lut_mem[0] = 24'h3000_11;
    lut_mem[1] = 24'h3001_22;
    lut_mem[2] = 24'h3002_33;
    lut_size = 8'd3;
    rst      = 1'b0;
    ae_valid = 1'b0;
    ae_time  = 16'h0000;
    ae_gain  = 16'h0000;
    vsync    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_req", 32'(i2c_req), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_exp", 32'(exp_applied), 32'd0);
    check_eq("rst_gain", 32'(gain_applied), 32'd0);
    check_eq("rst_cnt", 32'(update_cnt), 32'd0);
    check_eq("rst_lut_index", 32'(lut_index), 32'd0);

    // LUT walk of three entries
    rst = 1'b1;
    wait_init("init");
    check_eq("init_n", 32'(log_n), 32'd3);
    check_eq("init_w0", {log_addr[0], 8'h00, log_data[0]}, 32'h3000_0011);
    check_eq("init_w1", {log_addr[1], 8'h00, log_data[1]}, 32'h3001_0022);
    check_eq("init_w2", {log_addr[2], 8'h00, log_data[2]}, 32'h3002_0033);
    check_eq("init_busy", 32'(busy), 32'd0);
    check_eq("init_err", 32'(err), 32'd0);
    check_eq("init_lut_index", 32'(lut_index), 32'd3);
    repeat (2) @(negedge clk);

    // Single AE update, armed until vsync rises
    log_n = 0;
    pulse_ae(16'h0123, 16'd8);
    repeat (6) @(negedge clk);
    check_eq("armed_no_write", 32'(log_n), 32'd0);
    check_eq("armed_req", 32'(i2c_req), 32'd0);
    vsync = 1'b1;
    @(negedge clk);
    check_eq("vs_req", 32'(i2c_req), 32'd1);
    check_eq("vs_addr", 32'(i2c_addr), 32'h3208);
    check_eq("vs_busy", 32'(busy), 32'd1);
    wait_update(8'd1, "b1");
    check_burst("b1", 16'h0123, 8'h08);
    check_eq("b1_exp", 32'(exp_applied), 32'h0123);
    check_eq("b1_gain", 32'(gain_applied), 32'd8);
    check_eq("b1_busy", 32'(busy), 32'd0);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Two pulses before one frame edge: only the latest is written
    log_n = 0;
    pulse_ae(16'd100, 16'd5);
    pulse_ae(16'd200, 16'd6);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    wait_update(8'd2, "b2");
    check_burst("b2", 16'd200, 8'h06);
    check_eq("b2_exp", 32'(exp_applied), 32'd200);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Gain saturation
    log_n = 0;
    pulse_ae(16'h0400, 16'd300);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    wait_update(8'd3, "b3");
    check_burst("b3", 16'h0400, 8'hFF);
    check_eq("b3_gain", 32'(gain_applied), 32'hFF);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Repeating the committed values produces no burst
    log_n = 0;
    pulse_ae(16'h0400, 16'd300);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("same_n", 32'(log_n), 32'd0);
    check_eq("same_cnt", 32'(update_cnt), 32'd3);
    check_eq("same_busy", 32'(busy), 32'd0);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Every attempt on 3501 NACKed: four tries, err set, burst completes
    log_n = 0;
    err_addr = 16'h3501;
    pulse_ae(16'h0777, 16'd9);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    wait_update(8'd4, "b4");
    cnt3501 = 0;
    for (int i = 0; i < 8; i++) if (log_addr[i] == 16'h3501) cnt3501++;
    check_eq("nack_attempts", 32'(cnt3501), 32'd4);
    check_eq("nack_n", 32'(log_n), 32'd8);
    check_eq("nack_err", 32'(err), 32'd1);
    check_eq("nack_w5", {log_addr[5], 8'h00, log_data[5]}, 32'h3502_0077);
    check_eq("nack_w6", {log_addr[6], 8'h00, log_data[6]}, 32'h350B_0009);
    check_eq("nack_w7", {log_addr[7], 8'h00, log_data[7]}, 32'h3208_0010);
    check_eq("nack_exp", 32'(exp_applied), 32'h0777);
    err_addr = 16'hFFFF;
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while 3502 is outstanding
    hold_addr = 16'h3502;
    pulse_ae(16'h0ABC, 16'd1);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    begin : wait_3502
      int n;
      n = 0;
      while (!(i2c_req === 1'b1 && i2c_addr === 16'h3502) && n < 400) begin
        @(negedge clk);
        n++;
      end
      check_eq("hold_reach", 32'(i2c_req === 1'b1 && i2c_addr === 16'h3502), 32'd1);
    end
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(i2c_req), 32'd0);
    check_eq("mid_rst_lut_index", 32'(lut_index), 32'd0);
    check_eq("mid_rst_init_done", 32'(init_done), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    vsync = 1'b0;
    hold_addr = 16'hFFFF;
    lut_size = 8'd0;
    @(negedge clk);
    log_n = 0;
    rst = 1'b1;
    wait_init("init_empty");
    repeat (3) @(negedge clk);
    check_eq("empty_lut_n", 32'(log_n), 32'd0);
    check_eq("empty_lut_index", 32'(lut_index), 32'd0);
    check_eq("post_rst_cnt", 32'(update_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ae_sensor_write_sched.md
# ae_sensor_write_sched

Sequences all sensor register writes over the shared I2C master. It first walks the power-up configuration LUT, then commits AE exposure/gain updates as grouped-hold register bursts aligned to frame boundaries. It sits between the AE histogram engine (exposure_time, exposure_gain, post_valid), the config LUT and the 16-bit-address I2C write master. It is the single owner of that master's request port.

## Interface
- LUT_AW, 8: LUT index width
- EXP_REG_H, 16'h3501: exposure high-byte register
- EXP_REG_L, 16'h3502: exposure low-byte register
- GAIN_REG, 16'h350B: gain register
- HOLD_REG, 16'h3208: group-hold register; value 8'h00 opens the group, 8'h10 closes it
- MAX_RETRY, 3: extra attempts per write after the first failure

Ports:
- clk in 1: clock
- rst in 1: reset, asynchronous, active-low
- lut_index out LUT_AW: config LUT address
- lut_data in 24: {reg[15:0], val[7:0]}; combinational from lut_index
- lut_size in LUT_AW: number of LUT entries
- ae_valid in 1: one-cycle pulse, new AE result
- ae_time in 16: exposure time
- ae_gain in 16: exposure gain
- vsync in 1: frame sync; rising edge marks a frame boundary
- i2c_req out 1: write request
- i2c_addr out 16: register address
- i2c_data out 8: register value
- i2c_done in 1: one-cycle completion pulse
- i2c_err in 1: NACK flag, valid only with i2c_done
- init_done out 1: LUT walk finished (sticky)
- busy out 1: any write burst in progress
- err out 1: sticky flag, set when a write was dropped after retries
- exp_applied out 16: last committed exposure
- gain_applied out 8: last committed gain
- update_cnt out 8: committed AE bursts, wraps at 255 to 0

## Operation
- States: INIT_FETCH, INIT_WR, RUN_IDLE, ARMED, BURST_WR.
- INIT_FETCH: if lut_index == lut_size, set init_done and go to RUN_IDLE. Otherwise register lut_data and go to INIT_WR. lut_size = 0 gives init_done with no writes.
- INIT_WR: hold i2c_req until i2c_done.
  - On success: increment lut_index, return to INIT_FETCH.
  - On i2c_err: retry the same entry.
  - After MAX_RETRY failed retries: set err, skip the entry.
- ae_valid latches into pending registers {p_time, p_gain_sat} in every state, including during INIT. p_gain_sat = ae_gain saturated to 8'hFF. A newer pulse overwrites an older pending value, so only the latest value is kept.
- RUN_IDLE, with a pending value:
  - If the value equals {exp_applied, gain_applied}, clear pending and issue no writes.
  - Otherwise go to ARMED.
- ARMED: wait for the vsync rising edge, then snapshot pending into the working registers, clear pending and enter BURST_WR.
- BURST_WR: step counter 0..4 issues, in order:
  - HOLD_REG = 00
  - EXP_REG_H = time[15:8]
  - EXP_REG_L = time[7:0]
  - GAIN_REG = gain
  - HOLD_REG = 10
- Burst retry: same per-write retry rule as INIT. A dropped write sets err and the burst continues.
- Burst end: exp_applied and gain_applied update, update_cnt increments, state returns to RUN_IDLE.
- busy is high in INIT_FETCH, INIT_WR and BURST_WR.

## Timing
- Reset values: every output is 0, state INIT_FETCH, pending empty.
- vsync is registered once. The rising edge is detected on the cycle vsync_d = 0 and vsync = 1. i2c_req asserts on the following cycle.
- Handshake:
  - i2c_addr and i2c_data are stable while i2c_req is high.
  - i2c_req drops on the cycle after i2c_done.
  - Next request no earlier than 1 cycle later.
  - An i2c_done seen while i2c_req is low is ignored.
- ae_valid in the same cycle as the burst-start snapshot: the snapshot takes the old pending value, and the new value stays pending for the next frame.
- ae_valid is never lost. Pending clears only on snapshot or on the equal-value drop.
- A vsync edge during BURST_WR or INIT is ignored. The update waits for the next edge after ARMED is entered.
- Reset mid-burst: i2c_req drops asynchronously and the LUT walk restarts at index 0.
- Retry counter: 2 bits, cleared per write.

## Structure
- Shared package ae_pkg holds:
  - state enum
  - HOLD_OPEN = 8'h00, HOLD_CLOSE = 8'h10
  - default register-address constants, shared with AE top-level glue
- One natural sub-module: ae_i2c_retry, the single-write req/done/retry engine. It is used by both INIT_WR and BURST_WR.

## Test plan
- lut_size = 3, all i2c_done clean, no errors -> exactly 3 writes in LUT order, then init_done = 1, busy = 0.
- ae_valid(time = 16'h0123, gain = 16'd8) after init, then vsync edge -> writes in order 3208/00, 3501/01, 3502/23, 350B/08, 3208/10; exp_applied = 16'h0123, gain_applied = 8, update_cnt = 1.
- Two ae_valid pulses before one vsync edge (times 100, 200) -> one burst carrying 200.
- ae_gain = 300 -> GAIN_REG written with FF. Repeating the same values -> no burst, update_cnt unchanged.
- i2c_err on every attempt of 3501 -> 4 attempts, then err = 1. The burst completes the remaining 3 writes.
- rst asserted while 3502 is outstanding -> i2c_req = 0 immediately. After release, lut_index = 0 and init_done = 0.
